// File: rtl/ball_collision.sv
// Breakout collision probe engine: sweeps 7 points around the ball's next position, owns the brick bitmap.
// Latency: start at edge 0, done after edge 8; start while busy is dropped, not queued.
module ball_collision #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PADDLE_Y = 112,
    parameter int PADDLE_W = 16,
    parameter int BRICK_Y0 = 16,
    parameter int BRICK_W  = 16,
    parameter int BRICK_H  = 4,
    parameter int ROWS     = 4,
    parameter int COLS     = 10
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              start,
    input  logic                              new_game,
    input  logic [7:0]                        ball_x,
    input  logic [6:0]                        ball_y,
    input  logic                              h_q,
    input  logic                              v_q,
    input  logic [7:0]                        paddle_x,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        h_col_count,
    output logic [1:0]                        v_col_count,
    output logic [1:0]                        d_col_count,
    output logic                              paddle_collision,
    output logic                              ball_lost,
    output logic                              brick_hit,
    output logic [$clog2(ROWS)-1:0]           brick_row,
    output logic [$clog2(COLS)-1:0]           brick_col,
    output logic [$clog2(ROWS*COLS+1)-1:0]    bricks_left
);
    localparam int NB  = ROWS * COLS;
    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int LW  = $clog2(NB + 1);
    localparam int BIW = $clog2(NB);
    localparam int BWL = $clog2(BRICK_W);
    localparam int BHL = $clog2(BRICK_H);
    localparam logic signed [8:0] SW_S = 9'(SCREEN_W);
    localparam logic signed [7:0] SH_S = 8'(SCREEN_H);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [1:0]        acc_h_q, acc_h_d, acc_v_q, acc_v_d, acc_d_q, acc_d_d;
    logic              acc_pad_q, acc_pad_d, acc_lost_q, acc_lost_d;
    logic              lat_vld_q, lat_vld_d;
    logic [RW-1:0]     lat_row_q, lat_row_d;
    logic [CW-1:0]     lat_col_q, lat_col_d;
    logic [BIW-1:0]    lat_idx_q, lat_idx_d;
    logic [1:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, d_cnt_q, d_cnt_d;
    logic              pad_q, pad_d, lost_q, lost_d;
    logic              done_q, done_d, bhit_q, bhit_d;
    logic [RW-1:0]     brow_q, brow_d;
    logic [CW-1:0]     bcol_q, bcol_d;
    logic [LW-1:0]     left_q, left_d;
    logic [NB-1:0]     alive_q, alive_d;

    logic signed [8:0] bx_s, xh, px;
    logic signed [7:0] by_s, yv, py;
    logic [7:0]        x_u, col_full;
    logic [6:0]        y_u, dy, row_full;
    logic [BIW-1:0]    bidx;
    logic              wall, lost, on_pad, on_brick, hit;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

    // Probe point for the current index: 0..2 horizontal edge, 3..5 vertical edge, 6 diagonal.
    always_comb begin
        bx_s = $signed({1'b0, ball_x});
        by_s = $signed({1'b0, ball_y});
        xh   = h_q ? bx_s + 9'sd3 : bx_s - 9'sd1;
        yv   = v_q ? by_s + 8'sd3 : by_s - 8'sd1;
        px   = xh;
        py   = yv;
        if (idx_q < 3'd3) begin
            py = by_s + $signed({5'd0, idx_q});
        end else if (idx_q < 3'd6) begin
            px = bx_s + $signed({6'd0, idx_q - 3'd3});
        end
    end

    always_comb begin
        x_u      = px[7:0];
        y_u      = py[6:0];
        wall     = (px < 9'sd0) || (px >= SW_S) || (py < 8'sd0);
        lost     = !wall && (py >= SH_S);
        on_pad   = !wall && !lost
                   && (y_u >= 7'(PADDLE_Y)) && (y_u <= 7'(PADDLE_Y + 1))
                   && ({2'b00, x_u} >= {2'b00, paddle_x})
                   && ({2'b00, x_u} <= {2'b00, paddle_x} + 10'(PADDLE_W - 1));
        dy       = y_u - 7'(BRICK_Y0);
        row_full = dy >> BHL;
        col_full = x_u >> BWL;
        bidx     = BIW'(row_full * COLS + col_full);
        on_brick = !wall && !lost && !on_pad
                   && (y_u >= 7'(BRICK_Y0)) && (y_u <= 7'(BRICK_Y0 + ROWS * BRICK_H - 1))
                   && (col_full < 8'(COLS)) && alive_q[bidx];
        hit      = wall || on_pad || on_brick;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_h_d    = acc_h_q;
        acc_v_d    = acc_v_q;
        acc_d_d    = acc_d_q;
        acc_pad_d  = acc_pad_q;
        acc_lost_d = acc_lost_q;
        lat_vld_d  = lat_vld_q;
        lat_row_d  = lat_row_q;
        lat_col_d  = lat_col_q;
        lat_idx_d  = lat_idx_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        d_cnt_d    = d_cnt_q;
        pad_d      = pad_q;
        lost_d     = lost_q;
        done_d     = 1'b0;
        bhit_d     = 1'b0;
        brow_d     = brow_q;
        bcol_d     = bcol_q;
        left_d     = left_q;
        alive_d    = alive_q;
        case (state_q)
            S_IDLE: begin
                if (new_game) begin
                    alive_d = '1;
                    left_d  = LW'(NB);
                end
                if (start) begin
                    state_d    = S_PROBE;
                    idx_d      = 3'd0;
                    acc_h_d    = 2'd0;
                    acc_v_d    = 2'd0;
                    acc_d_d    = 2'd0;
                    acc_pad_d  = 1'b0;
                    acc_lost_d = 1'b0;
                    lat_vld_d  = 1'b0;
                end
            end
            S_PROBE: begin
                if (hit) begin
                    if (idx_q < 3'd3)      acc_h_d = sat_inc(acc_h_q);
                    else if (idx_q < 3'd6) acc_v_d = sat_inc(acc_v_q);
                    else                   acc_d_d = sat_inc(acc_d_q);
                end
                if (on_pad) acc_pad_d = 1'b1;
                if (lost && idx_q >= 3'd3 && idx_q < 3'd6) acc_lost_d = 1'b1;
                // Only the first brick in probe order is cleared; later ones still count.
                if (on_brick && !lat_vld_q) begin
                    lat_vld_d = 1'b1;
                    lat_row_d = RW'(row_full);
                    lat_col_d = CW'(col_full);
                    lat_idx_d = bidx;
                end
                if (idx_q == 3'd6) state_d = S_DONE;
                else               idx_d   = idx_q + 3'd1;
            end
            S_DONE: begin
                h_cnt_d = acc_h_q;
                v_cnt_d = acc_v_q;
                d_cnt_d = acc_d_q;
                pad_d   = acc_pad_q;
                lost_d  = acc_lost_q;
                done_d  = 1'b1;
                if (lat_vld_q) begin
                    alive_d[lat_idx_q] = 1'b0;
                    left_d             = left_q - LW'(1);
                    bhit_d             = 1'b1;
                    brow_d             = lat_row_q;
                    bcol_d             = lat_col_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_h_q    <= '0;
            acc_v_q    <= '0;
            acc_d_q    <= '0;
            acc_pad_q  <= 1'b0;
            acc_lost_q <= 1'b0;
            lat_vld_q  <= 1'b0;
            lat_row_q  <= '0;
            lat_col_q  <= '0;
            lat_idx_q  <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            d_cnt_q    <= '0;
            pad_q      <= 1'b0;
            lost_q     <= 1'b0;
            done_q     <= 1'b0;
            bhit_q     <= 1'b0;
            brow_q     <= '0;
            bcol_q     <= '0;
            left_q     <= LW'(NB);
            alive_q    <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_h_q    <= acc_h_d;
            acc_v_q    <= acc_v_d;
            acc_d_q    <= acc_d_d;
            acc_pad_q  <= acc_pad_d;
            acc_lost_q <= acc_lost_d;
            lat_vld_q  <= lat_vld_d;
            lat_row_q  <= lat_row_d;
            lat_col_q  <= lat_col_d;
            lat_idx_q  <= lat_idx_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            d_cnt_q    <= d_cnt_d;
            pad_q      <= pad_d;
            lost_q     <= lost_d;
            done_q     <= done_d;
            bhit_q     <= bhit_d;
            brow_q     <= brow_d;
            bcol_q     <= bcol_d;
            left_q     <= left_d;
            alive_q    <= alive_d;
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign h_col_count      = h_cnt_q;
    assign v_col_count      = v_cnt_q;
    assign d_col_count      = d_cnt_q;
    assign paddle_collision = pad_q;
    assign ball_lost        = lost_q;
    assign brick_hit        = bhit_q;
    assign brick_row        = brow_q;
    assign brick_col        = bcol_q;
    assign bricks_left      = left_q;
endmodule

// File: tb/tb_ball_collision.sv
// Scoreboard bench for ball_collision: directed sweeps push expected results, a monitor checks each done.
module tb_ball_collision;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       new_game = 1'b0;
    logic [7:0] ball_x = '0;
    logic [6:0] ball_y = '0;
    logic       h_q = 1'b0;
    logic       v_q = 1'b0;
    logic [7:0] paddle_x = '0;
    logic       busy, done, paddle_collision, ball_lost, brick_hit;
    logic [1:0] h_col_count, v_col_count, d_col_count;
    logic [1:0] brick_row;
    logic [3:0] brick_col;
    logic [5:0] bricks_left;

    ball_collision dut (
        .clock(clock), .resetn(resetn), .start(start), .new_game(new_game),
        .ball_x(ball_x), .ball_y(ball_y), .h_q(h_q), .v_q(v_q), .paddle_x(paddle_x),
        .busy(busy), .done(done),
        .h_col_count(h_col_count), .v_col_count(v_col_count), .d_col_count(d_col_count),
        .paddle_collision(paddle_collision), .ball_lost(ball_lost), .brick_hit(brick_hit),
        .brick_row(brick_row), .brick_col(brick_col), .bricks_left(bricks_left)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] h, v, d;
        logic       pc, lost, bh;
        logic [1:0] row;
        logic [3:0] col;
        logic [5:0] left;
        int         at;
    } exp_t;

    exp_t q[$];
    int vecs = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (brick_hit === 1'b1 && done !== 1'b1) chk("brick_hit_without_done", 32'(done), 1);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(q.size()), 1);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.at);
                    chk("busy_at_done", 32'(busy), 0);
                    chk("h_count", 32'(h_col_count), 32'(e.h));
                    chk("v_count", 32'(v_col_count), 32'(e.v));
                    chk("d_count", 32'(d_col_count), 32'(e.d));
                    chk("paddle_collision", 32'(paddle_collision), 32'(e.pc));
                    chk("ball_lost", 32'(ball_lost), 32'(e.lost));
                    chk("brick_hit", 32'(brick_hit), 32'(e.bh));
                    chk("bricks_left", 32'(bricks_left), 32'(e.left));
                    if (e.bh) begin
                        chk("brick_row", 32'(brick_row), 32'(e.row));
                        chk("brick_col", 32'(brick_col), 32'(e.col));
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 0);
            q.delete();
        end
        @(negedge clock);
    endtask

    task automatic launch(input logic [7:0] bx, input logic [6:0] by, input logic h, input logic v,
                          input logic ng, input logic push,
                          input logic [1:0] eh, input logic [1:0] ev, input logic [1:0] ed,
                          input logic epc, input logic elost, input logic ebh,
                          input logic [1:0] erow, input logic [3:0] ecol, input logic [5:0] eleft);
        exp_t e;
        @(negedge clock);
        ball_x = bx; ball_y = by; h_q = h; v_q = v;
        start = 1'b1; new_game = ng;
        e.h = eh; e.v = ev; e.d = ed; e.pc = epc; e.lost = elost; e.bh = ebh;
        e.row = erow; e.col = ecol; e.left = eleft; e.at = cyc + 9;
        if (push) q.push_back(e);
        @(negedge clock);
        start = 1'b0; new_game = 1'b0;
    endtask

    task automatic sweep(input logic [7:0] bx, input logic [6:0] by, input logic h, input logic v,
                         input logic ng,
                         input logic [1:0] eh, input logic [1:0] ev, input logic [1:0] ed,
                         input logic epc, input logic elost, input logic ebh,
                         input logic [1:0] erow, input logic [3:0] ecol, input logic [5:0] eleft);
        launch(bx, by, h, v, ng, 1'b1, eh, ev, ed, epc, elost, ebh, erow, ecol, eleft);
        wait_drain();
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_h"}, 32'(h_col_count), 0);
        chk({tag, "_v"}, 32'(v_col_count), 0);
        chk({tag, "_d"}, 32'(d_col_count), 0);
        chk({tag, "_paddle"}, 32'(paddle_collision), 0);
        chk({tag, "_lost"}, 32'(ball_lost), 0);
        chk({tag, "_brick_hit"}, 32'(brick_hit), 0);
        chk({tag, "_row"}, 32'(brick_row), 0);
        chk({tag, "_col"}, 32'(brick_col), 0);
        chk({tag, "_left"}, 32'(bricks_left), 40);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_idle_zero("reset");
        resetn = 1'b1;
        @(negedge clock);

        //    bx   by  h  v  ng  h  v  d  pc lost bh row col left
        sweep(80,  60, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0,  0,  40);
        sweep(157, 60, 1, 0, 0,  3, 0, 1, 0, 0,  0, 0,  0,  40);
        sweep(50,  0,  0, 0, 0,  0, 3, 1, 0, 0,  0, 0,  0,  40);
        paddle_x = 8'd40;
        sweep(44, 109, 1, 1, 0,  0, 3, 1, 1, 0,  0, 0,  0,  40);
        sweep(35,  32, 1, 0, 0,  0, 3, 1, 0, 0,  1, 3,  2,  39);
        sweep(35,  32, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0,  39);
        sweep(60, 118, 1, 1, 0,  0, 0, 0, 0, 1,  0, 0,  0,  39);

        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        @(negedge clock);
        chk("new_game_left", 32'(bricks_left), 40);
        chk("new_game_keeps_lost", 32'(ball_lost), 1);

        sweep(35,  32, 1, 0, 0,  0, 3, 1, 0, 0,  1, 3,  2,  39);
        // Restore and sweep in the same cycle: brick (3,2) is alive again for this sweep.
        sweep(35,  32, 1, 0, 1,  0, 3, 1, 0, 0,  1, 3,  2,  39);

        // Reset mid-sweep: no done, everything cleared, bricks restored.
        launch(80, 60, 1, 1, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        chk("busy_mid_sweep", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check_idle_zero("midreset");
        @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(negedge clock);

        // Start repeated during a sweep is dropped: exactly one done.
        launch(80, 60, 1, 1, 0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 40);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_dropped_start", 32'(busy), 1);
        wait_drain();
        repeat (12) @(negedge clock);
        chk("queue_empty_end", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
